// File: rtl/wb_pkg.sv
// Shared widths and MEM/WB bundle field positions for the write-back stage.
// The bundle is flat on the port; these constants and the struct name its fields.
// WB_RETIRE_CNT_EN (optional) adds a retired-write counter to wb_regfile.
package wb_pkg;

  localparam int DATA_W          = 32;
  localparam int ADDR_W          = 6;
  localparam int WB_BUNDLE_W     = 72;

  localparam int WB_REGWRITE_BIT = 0;
  localparam int WB_MEMTOREG_BIT = 1;
  localparam int WB_WREG_LSB     = 2;
  localparam int WB_WREG_MSB     = 7;
  localparam int WB_ALU_LSB      = 8;
  localparam int WB_ALU_MSB      = 39;
  localparam int WB_DM_LSB       = 40;
  localparam int WB_DM_MSB       = 71;

  // Same layout as the flat bundle, MSB first.
  typedef struct packed {
    logic [31:0] dm_out;
    logic [31:0] alu_out;
    logic [5:0]  write_reg;
    logic        mem_to_reg;
    logic        reg_write;
  } wb_bundle_t;

endpackage

// File: rtl/wb_rf_array.sv
// Register storage: NREGS x DATA_W, one synchronous write port, two async read ports.
// Write lands on the rising edge; reads are purely combinational on the stored contents.
// clr clears every entry asynchronously; a write on an edge with clr high is lost.
module wb_rf_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [NREGS];

  // Single write port with asynchronous clear of the whole array.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: decodes the MEM/WB bundle, commits into the register file,
// serves two decode read ports with same-cycle write-through bypass, and records the last write.
// Optional macro WB_RETIRE_CNT_EN adds retire_cnt, counting every RegWrite cycle (r0 writes included).
module wb_regfile
  import wb_pkg::*;
#(
  parameter int DATA_W   = wb_pkg::DATA_W,
  parameter int ADDR_W   = wb_pkg::ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [WB_BUNDLE_W-1:0] wb_bundle,
  input  logic [ADDR_W-1:0]      rs_addr,
  input  logic [ADDR_W-1:0]      rt_addr,
  output logic [DATA_W-1:0]      rs_data,
  output logic [DATA_W-1:0]      rt_data,
  output logic                   wb_we,
  output logic [ADDR_W-1:0]      wb_addr,
  output logic [DATA_W-1:0]      wb_data,
  output logic                   last_we,
  output logic [ADDR_W-1:0]      last_addr,
  output logic [DATA_W-1:0]      last_data
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]            retire_cnt
`endif
);

  logic              w_reg_write;
  logic              w_mem_to_reg;
  logic [ADDR_W-1:0] w_wreg;
  logic [DATA_W-1:0] w_alu_out;
  logic [DATA_W-1:0] w_dm_out;
  logic              w_wreg_is_zero;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  logic              r_last_we;
  logic [ADDR_W-1:0] r_last_addr;
  logic [DATA_W-1:0] r_last_data;

  assign w_reg_write  = wb_bundle[WB_REGWRITE_BIT];
  assign w_mem_to_reg = wb_bundle[WB_MEMTOREG_BIT];
  assign w_wreg       = wb_bundle[WB_WREG_MSB:WB_WREG_LSB];
  assign w_alu_out    = wb_bundle[WB_ALU_MSB:WB_ALU_LSB];
  assign w_dm_out     = wb_bundle[WB_DM_MSB:WB_DM_LSB];

  // Writes to r0 are dropped when r0 is hardwired, so they never reach the array or the bypass.
  assign w_wreg_is_zero = (w_wreg == '0);
  assign wb_we   = w_reg_write && !((ZERO_REG != 0) && w_wreg_is_zero);
  assign wb_addr = w_wreg;
  assign wb_data = w_mem_to_reg ? w_dm_out : w_alu_out;

  wb_rf_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk       (clk),
    .clr       (clr),
    .i_we      (wb_we),
    .i_waddr   (wb_addr),
    .i_wdata   (wb_data),
    .i_raddr_a (rs_addr),
    .i_raddr_b (rt_addr),
    .o_rdata_a (w_rd_a),
    .o_rdata_b (w_rd_b)
  );

  // Read port A: hardwired zero first, then bypass of the value committing at the coming edge.
  always_comb begin
    rs_data = w_rd_a;
    if ((ZERO_REG != 0) && (rs_addr == '0)) begin
      rs_data = '0;
    end else if (wb_we && (rs_addr == wb_addr)) begin
      rs_data = wb_data;
    end
  end

  // Read port B: same priority as port A.
  always_comb begin
    rt_data = w_rd_b;
    if ((ZERO_REG != 0) && (rt_addr == '0)) begin
      rt_data = '0;
    end else if (wb_we && (rt_addr == wb_addr)) begin
      rt_data = wb_data;
    end
  end

  // Last-write record for the hazard unit, one cycle behind the live write signals.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_last_we   <= 1'b0;
      r_last_addr <= '0;
      r_last_data <= '0;
    end else begin
      r_last_we   <= wb_we;
      r_last_addr <= wb_addr;
      r_last_data <= wb_data;
    end
  end

  assign last_we   = r_last_we;
  assign last_addr = r_last_addr;
  assign last_data = r_last_data;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  // Counts every RegWrite cycle, including dropped r0 writes; wraps naturally at 32 bits.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_retire_cnt <= '0;
    end else if (w_reg_write) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign retire_cnt = r_retire_cnt;
`endif

endmodule
